// File: rtl/multi_operand_accumulator_pkg.sv
// Shared definitions for the multi-operand accumulator.
//   state_e : FSM encoding of the sequential accumulator
//   clog2   : ceiling log2, used to size the sum and operand index
package multi_operand_accumulator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/multi_operand_accumulator_pb_edge_sync.sv
// Pushbutton conditioner: two-flop synchroniser followed by a rising-edge
// detector producing a single-cycle pulse.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   btn_i   : raw, asynchronous button level (active-high)
//   pulse_o : one-cycle pulse after the synchronised level first goes high
module pb_edge_sync
   import multi_operand_accumulator_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic pulse_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Because prev_q resets to 0, a button held through reset still produces
   // exactly one pulse once the synchroniser sees it after release.
   assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/multi_operand_accumulator.sv
// Multi-operand accumulator: NUM_OPS operand registers loaded from a shared
// switch bus by individual pushbuttons, summed sequentially one operand per
// clock. Any load restarts the summation; clr zeroes everything.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   pb        : raw load pushbuttons, pb[i] loads operand i from y
//   clr       : raw clear pushbutton
//   y         : operand value from switches (assumed stable around a press)
//   sum       : registered sum, held while a new sum is being computed
//   sum_valid : sum reflects current operand contents
//   busy      : accumulation pending or in progress
module multi_operand_accumulator
   import multi_operand_accumulator_pkg::*;
#(
   parameter  int WIDTH   = 4,
   parameter  int NUM_OPS = 5,
   localparam int SUM_W   = WIDTH + clog2(NUM_OPS)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_OPS-1:0] pb,
   input  logic               clr,
   input  logic [WIDTH-1:0]   y,
   output logic [SUM_W-1:0]   sum,
   output logic               sum_valid,
   output logic               busy
);

   localparam int IDX_W = clog2(NUM_OPS);

   logic [NUM_OPS-1:0] ld_pulse;
   logic               clr_pulse;
   logic               any_ld;

   for (genvar g = 0; g < NUM_OPS; g++) begin : g_pb
      pb_edge_sync u_pb (
         .clk     (clk),
         .rst_n   (rst_n),
         .btn_i   (pb[g]),
         .pulse_o (ld_pulse[g])
      );
   end

   pb_edge_sync u_clr (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (clr),
      .pulse_o (clr_pulse)
   );

   assign any_ld = |ld_pulse;

   logic [NUM_OPS-1:0][WIDTH-1:0] op_q, op_d;
   logic [SUM_W-1:0]              acc_q, acc_d;
   logic [IDX_W-1:0]              idx_q, idx_d;
   logic [SUM_W-1:0]              sum_q, sum_d;
   logic                          sum_valid_q, sum_valid_d;
   logic                          dirty_q, dirty_d;
   state_e                        state_q, state_d;

   always_comb begin
      op_d        = op_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      sum_d       = sum_q;
      sum_valid_d = sum_valid_q;
      dirty_d     = dirty_q;
      state_d     = state_q;

      for (int i = 0; i < NUM_OPS; i++) begin
         if (ld_pulse[i]) op_d[i] = y;
      end
      if (any_ld) sum_valid_d = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // A load coinciding with the start is still covered: the new
            // operand is in place before the first ACCUM cycle reads it.
            if (dirty_q) begin
               state_d = ST_ACCUM;
               acc_d   = '0;
               idx_d   = '0;
               dirty_d = 1'b0;
            end else if (any_ld) begin
               dirty_d = 1'b1;
            end
         end
         ST_ACCUM: begin
            if (any_ld) begin
               // Restart so the result always includes the newest operands.
               acc_d = '0;
               idx_d = '0;
            end else begin
               acc_d = acc_q + SUM_W'(op_q[idx_q]);
               if (idx_q == IDX_W'(NUM_OPS - 1)) begin
                  sum_d       = acc_d;
                  sum_valid_d = 1'b1;
                  state_d     = ST_DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Clear overrides everything, including same-cycle loads.
      if (clr_pulse) begin
         op_d        = '0;
         acc_d       = '0;
         idx_d       = '0;
         sum_d       = '0;
         sum_valid_d = 1'b1;
         dirty_d     = 1'b0;
         state_d     = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q        <= '0;
         acc_q       <= '0;
         idx_q       <= '0;
         sum_q       <= '0;
         sum_valid_q <= 1'b1;
         dirty_q     <= 1'b0;
         state_q     <= ST_IDLE;
      end else begin
         op_q        <= op_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         sum_q       <= sum_d;
         sum_valid_q <= sum_valid_d;
         dirty_q     <= dirty_d;
         state_q     <= state_d;
      end
   end

   assign sum       = sum_q;
   assign sum_valid = sum_valid_q;
   assign busy      = (state_q == ST_ACCUM) | dirty_q;

endmodule

// File: tb/tb_multi_operand_accumulator.sv
module tb_multi_operand_accumulator;

   localparam int N = 5;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] pb;
   logic         clr;
   logic [3:0]   y;
   logic [6:0]   sum;
   logic         sum_valid;
   logic         busy;

   logic [7:0]   pb8;
   logic         clr8;
   logic [7:0]   y8;
   logic [10:0]  sum8;
   logic         sum_valid8;
   logic         busy8;

   int n_chk;
   int n_err;
   int exp_op [N];

   multi_operand_accumulator #(.WIDTH(4), .NUM_OPS(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pb        (pb),
      .clr       (clr),
      .y         (y),
      .sum       (sum),
      .sum_valid (sum_valid),
      .busy      (busy)
   );

   multi_operand_accumulator #(.WIDTH(8), .NUM_OPS(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .pb        (pb8),
      .clr       (clr8),
      .y         (y8),
      .sum       (sum8),
      .sum_valid (sum_valid8),
      .busy      (busy8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint model_sum();
      longint s = 0;
      for (int i = 0; i < N; i++) s += exp_op[i];
      return s;
   endfunction

   // Press the buttons in mask with value val, wait for the new result and
   // check latency (edges from press to valid) and the sum.
   task automatic press(input logic [N-1:0] mask, input int val, input string tag);
      int cnt;
      bit seen_low;
      bit done;
      @(negedge clk);
      y  = 4'(val);
      pb = mask;
      cnt = 0;
      seen_low = 0;
      done = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         @(posedge clk);
         #1;
         cnt++;
         if (!sum_valid) seen_low = 1;
         else if (seen_low) done = 1;
      end
      for (int i = 0; i < N; i++) if (mask[i]) exp_op[i] = val;
      chk({tag, "_done"}, done, 1);
      chk({tag, "_latency"}, cnt, N + 4);
      chk({tag, "_sum"}, sum, model_sum());
      @(negedge clk);
      pb = '0;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_clr();
      @(negedge clk);
      clr = 1'b1;
      repeat (4) @(negedge clk);
      clr = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < N; i++) exp_op[i] = 0;
   endtask

   initial begin
      int rises;
      int lows;
      bit prev_v;
      bit started;
      bit gap;
      bit bad4;
      bit done;
      logic [N-1:0] m;
      int v;

      n_chk = 0;
      n_err = 0;
      for (int i = 0; i < N; i++) exp_op[i] = 0;
      rst_n = 1'b0;
      clr   = 1'b0;
      clr8  = 1'b0;
      pb8   = '0;
      y8    = '0;
      y     = 4'd6;
      pb    = 5'b00010;   // held through reset

      // Reset state, with a button held
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sum", sum, 0);
      chk("rst_valid", sum_valid, 1);
      chk("rst_busy", busy, 0);
      chk("rst_state", int'(dut.state_q), 0);

      @(negedge clk);
      rst_n = 1'b1;
      rises = 0;
      prev_v = 1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) begin
            chk("rel_valid", sum_valid, 1);
            chk("rel_busy", busy, 0);
         end
         if (sum_valid && !prev_v) rises++;
         prev_v = sum_valid;
      end
      exp_op[1] = 6;
      chk("held_rises", rises, 1);
      chk("held_sum", sum, 6);
      @(negedge clk);
      pb = '0;
      repeat (3) @(negedge clk);

      // Directed operand sequence
      press(5'b00001, 3, "ld0");
      press(5'b00010, 5, "ld1");
      press(5'b00100, 7, "ld2");
      press(5'b01000, 9, "ld3");
      press(5'b10000, 1, "ld4");
      chk("seq_25", sum, 25);

      // Maximum operands, simultaneous presses
      press(5'b11111, 15, "all15");
      chk("max_75", sum, 75);

      @(negedge clk);
      y8  = 8'd255;
      pb8 = 8'hFF;
      done = 0;
      bad4 = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         @(posedge clk);
         #1;
         if (!sum_valid8) bad4 = 1;
         else if (bad4) done = 1;
      end
      chk("w8_done", done, 1);
      chk("w8_sum", sum8, 2040);
      @(negedge clk);
      pb8 = '0;

      // Restart on a load during accumulation
      do_clr();
      chk("clr0_sum", sum, 0);
      @(negedge clk);
      y  = 4'd4;
      pb = 5'b00001;
      rises = 0;
      prev_v = 1;
      started = 0;
      gap = 0;
      bad4 = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (sum_valid && !prev_v) rises++;
         if (sum_valid && sum == 7'd4) bad4 = 1;
         if (busy) started = 1;
         if (started && rises == 0 && !busy) gap = 1;
         prev_v = sum_valid;
         if (c == 5) begin
            y  = 4'd6;
            pb = 5'b00010;
         end
      end
      exp_op[0] = 4;
      exp_op[1] = 6;
      chk("rs_rises", rises, 1);
      chk("rs_no4", bad4, 0);
      chk("rs_busy_gap", gap, 0);
      chk("rs_sum", sum, model_sum());
      chk("rs_idle_busy", busy, 0);
      @(negedge clk);
      pb = '0;
      repeat (3) @(negedge clk);

      // Clear beats a same-cycle load
      press(5'b00001, 1, "c0");
      press(5'b00010, 2, "c1");
      press(5'b00100, 3, "c2");
      press(5'b01000, 4, "c3");
      press(5'b10000, 5, "c4");
      chk("c_15", sum, 15);
      @(negedge clk);
      y   = 4'd9;
      pb  = 5'b00100;
      clr = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) exp_op[i] = 0;
      chk("clr_sum", sum, 0);
      chk("clr_valid", sum_valid, 1);
      chk("clr_busy", busy, 0);
      chk("clr_state", int'(dut.state_q), 0);
      @(negedge clk);
      pb  = '0;
      clr = 1'b0;
      repeat (3) @(negedge clk);
      press(5'b00001, 1, "after_clr");

      // Randomized loads
      for (int k = 0; k < 12; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            m = 5'($urandom_range(1, 31));
         end else begin
            m = 5'b00001 << $urandom_range(0, N - 1);
         end
         v = int'($urandom_range(0, 15));
         press(m, v, "rnd");
      end

      // Asynchronous reset during accumulation
      @(negedge clk);
      y  = 4'd7;
      pb = 5'b01000;
      repeat (4) @(posedge clk);
      #1;
      pb = '0;
      @(posedge clk);
      #3;
      chk("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_sum", sum, 0);
      chk("arst_valid", sum_valid, 1);
      chk("arst_busy", busy, 0);
      for (int i = 0; i < N; i++) exp_op[i] = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      lows = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (!sum_valid || sum != 0 || busy) lows++;
      end
      chk("post_rst_quiet", lows, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/multi_operand_accumulator.md
Name: multi_operand_accumulator

Overview:
- Parametrised successor of the pushbutton-loaded five-operand adder.
- NUM_OPS operand registers of WIDTH bits, each loaded from a shared switch bus y by its own pushbutton.
- Sum is computed sequentially, one operand per clock, with a valid/busy indication.
- Adds input synchronisation, edge detection, a clear function and restart-on-change semantics. Sits between board pushbuttons/switches and the LED/7-segment display logic.

Parameters:
- WIDTH, 4, operand width in bits.
- NUM_OPS, 5, number of operand registers (≥2).
- Derived localparam SUM_W = WIDTH + $clog2(NUM_OPS). Not overridable.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- pb  input  NUM_OPS  raw pushbuttons, active-high; pb[i] loads operand i.
- clr  input  1  raw pushbutton, active-high; clears all operands.
- y  input  WIDTH  operand value from switches.
- sum  output  SUM_W  registered sum of all operands.
- sum_valid  output  1  sum reflects current operand contents.
- busy  output  1  accumulation pending or in progress.

Behaviour:
- Reset (async assert, sync release): operands=0, sum=0, sum_valid=1, busy=0, FSM=IDLE, dirty=0, all sync and edge flops=0.
- Button conditioning:
  - Each pb[i] and clr passes a 2-flop synchroniser, then a rising-edge detect, giving a 1-cycle pulse.
  - The pulse is high in the cycle after the 2nd sync flop first captures 1.
  - A button held through reset yields exactly one pulse after release.
  - A held button yields no further pulses.
- Load:
  - On a load pulse for i, op[i] <= y at that clock edge. y is a static switch input and must be stable for ≥3 cycles around a press; it is not synchronised.
  - Multiple simultaneous pulses all load the same y.
  - Any load sets dirty and clears sum_valid at the same edge.
- clr pulse:
  - All op <= 0, sum <= 0, sum_valid <= 1, dirty <= 0, FSM <= IDLE.
  - clr wins over load pulses in the same cycle; those loads are dropped.
- FSM states IDLE, ACCUM, DONE:
  - IDLE/DONE with dirty=1 -> ACCUM: acc=0, idx=0, dirty cleared.
  - ACCUM: acc <= acc + op[idx], idx++.
  - After adding op[NUM_OPS-1]: sum <= final acc, sum_valid <= 1, -> DONE.
  - ACCUM with a load pulse in the same cycle: restart. acc=0, idx=0, stay ACCUM, dirty stays clear, sum_valid stays 0.
  - DONE is otherwise stable. DONE vs IDLE differ only for observability (IDLE only after reset/clr).
- Latency: load pulse in cycle t -> ACCUM cycles t+2 … t+1+NUM_OPS -> sum/sum_valid updated at the end of cycle t+1+NUM_OPS.
- busy = (FSM==ACCUM) | dirty, combinational from registers.
- Arithmetic: unsigned; acc is SUM_W bits; overflow impossible by construction.
- sum holds its old value while sum_valid=0. It changes only on completion, clr or reset.
- Reset mid-ACCUM: immediate return to reset values; the partial sum is discarded.

Decomposition:
- Shared package/include:
  - FSM state encodings (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2).
  - clog2 constant function used for SUM_W and idx width.
- One natural sub-module: pb_edge_sync (2-flop sync + rising-edge pulse, async active-low reset), instantiated NUM_OPS+1 times via generate.

Test Plan:
- Release reset with no presses -> sum=0, sum_valid=1, busy=0, FSM=IDLE; pb held through reset -> exactly one load after release.
- WIDTH=4, NUM_OPS=5: load y=3,5,7,9,1 into op0..op4, waiting for valid each time -> final sum=25. Each completion arrives NUM_OPS+2 cycles after its load pulse, with sum_valid=0 in between.
- All five operands loaded with 15 -> sum=75 (7'h4B); repeat with WIDTH=8, NUM_OPS=8, all 255 -> sum=2040 (SUM_W=11).
- From all-zero state:
  - Press pb[0] with y=4.
  - 2 cycles into ACCUM, press pb[1] with y=6.
  - Expect: sum_valid never high with sum=4; a single rising edge with sum=10; busy continuous.
- Operands 1,2,3,4,5 loaded (sum=15); clr and pb[2] (y=9) pulse in the same cycle -> all op=0, sum=0, sum_valid=1, FSM=IDLE; op2 not loaded.
- Assert rst_n low mid-ACCUM (asynchronous to clk) -> sum=0, sum_valid=1, busy=0 immediately, before the next clk edge; no spurious completion after release.
